// File: rtl/store_write_buffer.sv
// In-order store write buffer between the store data queue and the data-memory write port.
// Issue-to-request latency is two cycles; with zero-wait acks it drains one store per cycle.
// Optional store-to-load forwarding is enabled with the STB_FWD_EN macro.
module store_write_buffer #(
    parameter int WB_ENTRIES = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    output logic                          sdq_issue_en_o,
    input  logic                          sdq_issue_vld_i,
    input  logic [31:0]                   sdq_issue_addr_i,
    input  logic [31:0]                   sdq_issue_data_i,
    output logic                          mem_wr_req_o,
    output logic [31:0]                   mem_wr_addr_o,
    output logic [31:0]                   mem_wr_data_o,
    input  logic                          mem_wr_ack_i,
    output logic                          wb_empty_o,
    output logic [$clog2(WB_ENTRIES):0]   wb_count_o,
    input  logic                          ld_vld_i,
    input  logic [31:0]                   ld_addr_i,
    output logic                          ld_hit_o,
    output logic [31:0]                   ld_data_o
);

    localparam int IW = $clog2(WB_ENTRIES);
    localparam int PW = IW + 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(WB_ENTRIES);

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     ent_addr [WB_ENTRIES];
    logic [31:0]     ent_data [WB_ENTRIES];
    logic [PW-1:0]   head_q, tail_q, count;
    logic [IW-1:0]   head_idx, nxt_idx, tail_idx;
    logic [CW-1:0]   occ_in;
    logic [31:0]     wr_addr_q, wr_data_q, load_addr, load_data;
    logic            empty, full, push, pop, load;

    assign head_idx = head_q[IW-1:0];
    assign tail_idx = tail_q[IW-1:0];
    assign nxt_idx  = head_idx + IW'(1);
    assign count    = tail_q - head_q;
    assign empty    = (head_q == tail_q);
    assign full     = (head_q[IW] != tail_q[IW]) && (head_idx == tail_idx);

    // A store arriving while full is a protocol violation and is dropped.
    assign push     = sdq_issue_vld_i && !full;
    assign pop      = (state_q == REQ) && mem_wr_ack_i;

    // The store already in flight from the queue must also have a slot reserved.
    assign occ_in         = {1'b0, count} + {{PW{1'b0}}, sdq_issue_vld_i};
    assign sdq_issue_en_o = (occ_in < DEPTH);

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        load_addr = ent_addr[head_idx];
        load_data = ent_data[head_idx];
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = REQ;
                    load    = 1'b1;
                end
            end
            REQ: begin
                if (mem_wr_ack_i) begin
                    if (count > PW'(1)) begin
                        load      = 1'b1;
                        load_addr = ent_addr[nxt_idx];
                        load_data = ent_data[nxt_idx];
                    end else if (push) begin
                        // Last entry popped while a new one lands: bypass it straight to the port.
                        load      = 1'b1;
                        load_addr = sdq_issue_addr_i;
                        load_data = sdq_issue_data_i;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q    <= '0;
            tail_q    <= '0;
            state_q   <= IDLE;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            if (push) tail_q <= tail_q + PW'(1);
            if (pop)  head_q <= head_q + PW'(1);
            state_q <= state_d;
            if (load) begin
                wr_addr_q <= load_addr;
                wr_data_q <= load_data;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            ent_addr[tail_idx] <= sdq_issue_addr_i;
            ent_data[tail_idx] <= sdq_issue_data_i;
        end
    end

    assign mem_wr_req_o  = (state_q == REQ);
    assign mem_wr_addr_o = wr_addr_q;
    assign mem_wr_data_o = wr_data_q;
    assign wb_empty_o    = empty && (state_q == IDLE);
    assign wb_count_o    = count;

`ifdef STB_FWD_EN
    logic [IW-1:0] fwd_idx;

    // Scan oldest to youngest so the youngest matching store wins.
    always_comb begin
        ld_hit_o  = 1'b0;
        ld_data_o = '0;
        fwd_idx   = head_idx;
        for (int i = 0; i < WB_ENTRIES; i++) begin
            fwd_idx = head_idx + IW'(i);
            if (ld_vld_i && (PW'(i) < count) && (ent_addr[fwd_idx] == ld_addr_i)) begin
                ld_hit_o  = 1'b1;
                ld_data_o = ent_data[fwd_idx];
            end
        end
    end
`else
    logic unused_ld;

    assign unused_ld = ^{ld_vld_i, ld_addr_i};
    assign ld_hit_o  = 1'b0;
    assign ld_data_o = '0;
`endif

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer with a queue-based reference model checked every cycle.
module tb_store_write_buffer;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst, en, vld, req, ack, wb_empty, ld_vld, ld_hit;
    logic [31:0] addr, data, waddr, wdata, ld_addr, ld_data;
    logic [2:0]  wb_count;

    always #5 clk = ~clk;

    store_write_buffer #(.WB_ENTRIES(N)) dut (
        .clk_i(clk), .rst_i(rst),
        .sdq_issue_en_o(en), .sdq_issue_vld_i(vld),
        .sdq_issue_addr_i(addr), .sdq_issue_data_i(data),
        .mem_wr_req_o(req), .mem_wr_addr_o(waddr), .mem_wr_data_o(wdata),
        .mem_wr_ack_i(ack), .wb_empty_o(wb_empty), .wb_count_o(wb_count),
        .ld_vld_i(ld_vld), .ld_addr_i(ld_addr), .ld_hit_o(ld_hit), .ld_data_o(ld_data)
    );

    typedef struct { logic [31:0] a; logic [31:0] d; } ent_t;
    typedef struct { int c; logic [31:0] a; logic [31:0] d; } wr_t;

    ent_t m_q[$];
    wr_t  log_q[$];
    bit   m_prev_ne = 1'b0;
    bit   cmp_on = 1'b0;
    bit   perm = 1'b1;
    bit   ack_rand = 1'b0;
    bit   ack_val = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: buffer contents as a queue; a request is up in any cycle where the
    // buffer is non-empty and was also non-empty the cycle before.
    always @(posedge clk) begin : model
        bit rq, fl;
        cyc++;
        rq = (m_q.size() > 0) && m_prev_ne;
        fl = (m_q.size() == N);
        if (cmp_on && !rst)
            assert (!(vld && fl)) else $error("store issued into a full buffer");
        if (rst) begin
            m_q.delete();
            m_prev_ne = 1'b0;
        end else begin
            m_prev_ne = (m_q.size() > 0);
            if (rq && ack) void'(m_q.pop_front());
            if (vld && !fl) m_q.push_back('{a: addr, d: data});
        end
    end

    always @(negedge clk) begin : compare
        bit          ereq, ehit;
        logic [31:0] edata;
        if (cmp_on) begin
            ereq  = (m_q.size() > 0) && m_prev_ne;
            ehit  = 1'b0;
            edata = '0;
`ifdef STB_FWD_EN
            if (ld_vld)
                foreach (m_q[i])
                    if (m_q[i].a == ld_addr) begin
                        ehit  = 1'b1;
                        edata = m_q[i].d;
                    end
`endif
            chk("count", 32'(wb_count), 32'(m_q.size()));
            chk("empty", 32'(wb_empty), 32'(m_q.size() == 0));
            chk("issue_en", 32'(en), 32'((m_q.size() + int'(vld)) < N));
            chk("req", 32'(req), 32'(ereq));
            if (ereq) begin
                chk("wr_addr", waddr, m_q[0].a);
                chk("wr_data", wdata, m_q[0].d);
            end
            chk("ld_hit", 32'(ld_hit), 32'(ehit));
            chk("ld_data", ld_data, edata);
            if (req && ack) log_q.push_back('{c: cyc, a: waddr, d: wdata});
        end
    end

    task automatic step(input bit v, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        vld  = v;
        addr = a;
        data = d;
        ack  = ack_rand ? 1'($urandom_range(0, 1)) : ack_val;
        #1;
        perm = en;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        while (!perm && n < 100) begin
            step(1'b0, 32'h0, 32'h0);
            n++;
        end
        chk("push_perm", 32'(perm), 32'd1);
        if (perm) step(1'b1, a, d);
    endtask

    task automatic wait_req();
        int n = 0;
        while (!req && n < 50) begin
            step(1'b0, 32'h0, 32'h0);
            n++;
        end
        chk("wait_req", 32'(req), 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        ack_rand = 1'b0;
        ack_val  = 1'b1;
        while (!wb_empty && n < 100) begin
            step(1'b0, 32'h0, 32'h0);
            n++;
        end
        step(1'b0, 32'h0, 32'h0);
        chk("drain_empty", 32'(wb_empty), 32'd1);
        ack_val = 1'b0;
    endtask

    initial begin
        rst = 1'b1; vld = 1'b0; addr = '0; data = '0; ack = 1'b0;
        ld_vld = 1'b0; ld_addr = '0;

        // Reset values
        step(1'b0, 32'h0, 32'h0);
        cmp_on = 1'b1;
        step(1'b0, 32'h0, 32'h0);
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_addr", waddr, 32'h0);
        chk("rst_data", wdata, 32'h0);
        chk("rst_count", 32'(wb_count), 32'd0);
        chk("rst_empty", 32'(wb_empty), 32'd1);
        chk("rst_en", 32'(en), 32'd1);
        chk("rst_hit", 32'(ld_hit), 32'd0);
        chk("rst_lddata", ld_data, 32'h0);
        rst = 1'b0;
        step(1'b0, 32'h0, 32'h0);

        // Single store with ack held high
        ack_val = 1'b1;
        push(32'h100, 32'hDEADBEEF);
        step(1'b0, 32'h0, 32'h0);
        chk("single_req_n1", 32'(req), 32'd0);
        step(1'b0, 32'h0, 32'h0);
        chk("single_req_n2", 32'(req), 32'd1);
        chk("single_addr", waddr, 32'h100);
        chk("single_data", wdata, 32'hDEADBEEF);
        step(1'b0, 32'h0, 32'h0);
        chk("single_req_done", 32'(req), 32'd0);
        chk("single_empty", 32'(wb_empty), 32'd1);

        // Backpressure: four stores, ack held low
        ack_val = 1'b0;
        for (int i = 0; i < 4; i++) push(32'h200 + 32'(4 * i), 32'hA0 + 32'(i));
        chk("bp_en_full", 32'(en), 32'd0);
        step(1'b0, 32'h0, 32'h0);
        chk("bp_count", 32'(wb_count), 32'd4);
        chk("bp_en", 32'(en), 32'd0);
        repeat (20) step(1'b0, 32'h0, 32'h0);
        chk("bp_hold_req", 32'(req), 32'd1);
        chk("bp_hold_addr", waddr, 32'h200);
        chk("bp_hold_data", wdata, 32'hA0);
        log_q.delete();
        ack_val = 1'b1;
        repeat (5) step(1'b0, 32'h0, 32'h0);
        chk("bp_nwrites", 32'(log_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            chk("bp_wr_addr", log_q[i].a, 32'h200 + 32'(4 * i));
            chk("bp_wr_data", log_q[i].d, 32'hA0 + 32'(i));
        end
        if (log_q.size() >= 4) chk("bp_b2b_span", 32'(log_q[3].c - log_q[0].c), 32'd3);
        chk("bp_empty", 32'(wb_empty), 32'd1);

        // Push and pop in the same cycle
        ack_val = 1'b0;
        push(32'h300, 32'h11);
        push(32'h304, 32'h22);
        wait_req();
        chk("sim_count_before", 32'(wb_count), 32'd2);
        ack_val = 1'b1;
        push(32'h308, 32'h33);
        ack_val = 1'b0;
        step(1'b0, 32'h0, 32'h0);
        chk("sim_count_after", 32'(wb_count), 32'd2);
        chk("sim_req", 32'(req), 32'd1);
        chk("sim_next_addr", waddr, 32'h304);
        chk("sim_next_data", wdata, 32'h22);
        drain();

        // Wrap-around stream with random acks
        log_q.delete();
        ack_rand = 1'b1;
        for (int i = 0; i < 10; i++) push(32'(4 * i), 32'h1000 + 32'(i));
        drain();
        chk("wrap_nwrites", 32'(log_q.size()), 32'd10);
        for (int i = 0; i < 10 && i < log_q.size(); i++) begin
            chk("wrap_addr", log_q[i].a, 32'(4 * i));
            chk("wrap_data", log_q[i].d, 32'h1000 + 32'(i));
        end

        // Load lookup against buffered stores
        push(32'h40, 32'h1);
        push(32'h40, 32'h2);
        push(32'h80, 32'h3);
        wait_req();
        ld_vld = 1'b1;
        ld_addr = 32'h40;
        #1;
`ifdef STB_FWD_EN
        chk("fwd_hit_40", 32'(ld_hit), 32'd1);
        chk("fwd_data_40", ld_data, 32'h2);
`else
        chk("fwd_hit_40", 32'(ld_hit), 32'd0);
        chk("fwd_data_40", ld_data, 32'h0);
`endif
        ld_addr = 32'h44;
        #1;
        chk("fwd_hit_44", 32'(ld_hit), 32'd0);
        chk("fwd_data_44", ld_data, 32'h0);
        ld_addr = 32'h80;
        #1;
`ifdef STB_FWD_EN
        chk("fwd_data_80", ld_data, 32'h3);
`else
        chk("fwd_data_80", ld_data, 32'h0);
`endif
        ld_addr = 32'h40;
        drain();
        ld_vld = 1'b0;

        // Reset while a write is outstanding
        push(32'h500, 32'h5);
        push(32'h504, 32'h6);
        push(32'h508, 32'h7);
        wait_req();
        step(1'b0, 32'h0, 32'h0);
        chk("rmw_count", 32'(wb_count), 32'd3);
        rst = 1'b1;
        step(1'b0, 32'h0, 32'h0);
        chk("rmw_req", 32'(req), 32'd0);
        chk("rmw_count0", 32'(wb_count), 32'd0);
        chk("rmw_empty", 32'(wb_empty), 32'd1);
        chk("rmw_en", 32'(en), 32'd1);
        rst = 1'b0;
        repeat (2) step(1'b0, 32'h0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
